// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants, types and the digit formatting helper for the
// BCD display-word encoder.
//   BIN_W / NDIG / CODE_W : binary input width, digit count, display code width
//   BLANK_CODE / DASH_CODE: special display codes understood by the scanner
//   state_t               : encoder FSM states
//   ssd_word_t            : packed {d3,d2,d1,d0} display word
package ssd_pkg;

  localparam int BIN_W  = 14;
  localparam int NDIG   = 4;
  localparam int CODE_W = 5;
  localparam int WORD_W = NDIG * CODE_W;
  localparam int BCD_W  = 4 * NDIG;

  localparam logic [CODE_W-1:0] BLANK_CODE = 5'd16;
  localparam logic [CODE_W-1:0] DASH_CODE  = 5'd17;
  localparam logic [BIN_W-1:0]  MAX_VAL    = 14'd9999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FORMAT = 2'd2
  } state_t;

  typedef logic [WORD_W-1:0] ssd_word_t;

  localparam ssd_word_t ALL_BLANK = {NDIG{BLANK_CODE}};
  localparam ssd_word_t ALL_DASH  = {NDIG{DASH_CODE}};

  // Turns the BCD accumulator into display codes. With blank_lz set, zero
  // digits are blanked from the most significant end until the first
  // nonzero digit; the units digit always shows so that 0 reads as "0".
  function automatic ssd_word_t format_word(input logic [BCD_W-1:0] bcd,
                                            input logic             blank_lz);
    ssd_word_t w;
    logic      lead;
    w    = '0;
    lead = blank_lz;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (lead && (i != 0) && (bcd[4*i +: 4] == 4'd0)) begin
        w[CODE_W*i +: CODE_W] = BLANK_CODE;
      end else begin
        w[CODE_W*i +: CODE_W] = {{(CODE_W-4){1'b0}}, bcd[4*i +: 4]};
        lead                  = 1'b0;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/ssd_bcd_add3.sv
// ssd_bcd_add3: one double-dabble correction cell. A nibble of 5 or more is
// bumped by 3 so that the following left shift carries into the next digit.
//   d : BCD nibble before correction
//   q : corrected nibble
module ssd_bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/ssd_bcd_encoder.sv
// ssd_bcd_encoder: converts a 14-bit binary value (0..9999) into the packed
// 20-bit display word {d3,d2,d1,d0} for the seven-segment scanner, using
// shift-add-3 one bit per clock. Values above 9999 display four dashes.
//
// Ports:
//   clk      : system clock, posedge
//   rst      : synchronous active-high reset
//   start    : conversion request, only looked at while idle
//   bin_in   : binary value, captured on the edge that accepts start
//   busy     : high from the accepting edge through the FORMAT edge
//   done     : one-cycle pulse when a new ssd_word first appears
//   ssd_word : registered display word, only changes at FORMAT or reset
//
// Build option: define SSD_LEADING_ZERO_BLANK_EN to blank leading zero digits.
//
// Handshake: start is accepted on a rising edge only while the FSM is idle;
// that edge raises busy. Exactly 15 edges later ssd_word updates, done pulses
// for one cycle and busy falls. start while busy is dropped, never queued, so
// a held start re-arms on the edge after done (16-clock period).
module ssd_bcd_encoder
  import ssd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BIN_W-1:0]  bin_in,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] ssd_word
);

`ifdef SSD_LEADING_ZERO_BLANK_EN
  localparam logic BLANK_LZ = 1'b1;
`else
  localparam logic BLANK_LZ = 1'b0;
`endif

  // Counter value of the final shift step (one step per input bit).
  localparam logic [3:0] LAST_CNT = 4'(BIN_W - 1);

  // Current FSM state; kept as a named signal so checkers can bind to it.
  state_t           state;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_adj;
  logic [3:0]       cnt;
  logic             ovf;

  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    ssd_bcd_add3 u_add3 (
      .d (bcd_q[4*g +: 4]),
      .q (bcd_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ssd_word <= ALL_BLANK;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_q <= bin_in;
            bcd_q <= '0;
            cnt   <= '0;
            ovf   <= (bin_in > MAX_VAL);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // Correct every digit first, then move the next binary bit in.
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt            <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            state <= FORMAT;
          end
        end
        FORMAT: begin
          ssd_word <= ovf ? ALL_DASH : format_word(bcd_q, BLANK_LZ);
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssd_bcd_encoder.sv
// tb_ssd_bcd_encoder: self-checking bench for ssd_bcd_encoder. A behavioural
// model (decimal arithmetic plus a completion countdown) predicts busy, done
// and ssd_word every cycle; directed cases pin literal words and latencies.
module tb_ssd_bcd_encoder;

`ifdef SSD_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic [19:0] ssd_word;

  always #5 clk = ~clk;

  ssd_bcd_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .ssd_word (ssd_word)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [19:0] ref_word(input int v);
    logic [19:0] w;
    int          d[4];
    bit          lead;
    if (v > 9999) return {4{5'd17}};
    d[0] = v % 10;
    d[1] = (v / 10) % 10;
    d[2] = (v / 100) % 10;
    d[3] = v / 1000;
    lead = LZ;
    w    = '0;
    for (int i = 3; i >= 0; i--) begin
      if (lead && i > 0 && d[i] == 0) w[5*i +: 5] = 5'd16;
      else begin
        w[5*i +: 5] = 5'(d[i]);
        lead = 1'b0;
      end
    end
    return w;
  endfunction

  logic [19:0] exp_q[$];
  logic [19:0] pending;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [19:0] m_word = 20'h84210;
  int          m_left = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          prev_done_cyc = 0;
  bit          chk_en = 1'b0;
  bit          b2b_mode = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_word = 20'h84210;
      m_left = 0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_word = pending;
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else if (start) begin
        m_left  = 15;
        m_busy  = 1'b1;
        pending = ref_word(int'(bin_in));
        exp_q.push_back(pending);
      end
    end
  end

  // ---------------- compare process / scoreboard ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'b0, busy}, {31'b0, m_busy});
      check("done", {31'b0, done}, {31'b0, m_done});
      check("ssd_word", {12'b0, ssd_word}, {12'b0, m_word});
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: done with no expected word, got %h at %0t", ssd_word, $time);
        end else begin
          check("scoreboard", {12'b0, ssd_word}, {12'b0, exp_q.pop_front()});
        end
        if (b2b_mode && prev_done_cyc > 0) check("b2b_period", cyc - prev_done_cyc, 16);
        prev_done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One conversion; returns cycles to done and busy-high cycle count.
  task automatic run_one(input logic [13:0] v, output int lat, output int bcnt);
    wait_idle();
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 14'($urandom_range(0, 16383));
    lat    = 0;
    bcnt   = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic convert(input logic [13:0] v, input logic [19:0] lit, input string name);
    int lat, bcnt;
    run_one(v, lat, bcnt);
    check({name, "_latency"}, lat, 15);
    check({name, "_busy_cycles"}, bcnt, 15);
    check({name, "_word"}, {12'b0, ssd_word}, {12'b0, lit});
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, bcnt, d0;
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clk);
    check("reset_word", {12'b0, ssd_word}, 32'h84210);
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_done", {31'b0, done}, 0);
    rst    = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    convert(14'd1234, 20'h08864, "v1234");
    convert(14'd9999, 20'h4A529, "v9999");
    convert(14'd42, LZ ? 20'h84082 : 20'h00082, "v42");
    convert(14'd0, LZ ? 20'h84200 : 20'h00000, "v0");
    convert(14'd12000, 20'h8C631, "ovf12000");
    convert(14'd10000, 20'h8C631, "ovf10000");

    // start pulses while busy must be dropped
    d0 = done_cnt;
    wait_idle();
    start = 1'b1; bin_in = 14'd1234;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; bin_in = 14'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; bin_in = 14'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    check("ignore_done_count", done_cnt - d0, 1);
    check("ignore_word", {12'b0, ssd_word}, 32'h08864);

    // held start: back-to-back every 16 clocks, bin_in varies every cycle
    wait_idle();
    d0       = done_cnt;
    b2b_mode = 1'b1;
    prev_done_cyc = 0;
    start    = 1'b1;
    for (int i = 0; i < 84; i++) begin
      bin_in = 14'($urandom_range(0, 16383));
      @(negedge clk);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    b2b_mode = 1'b0;
    check("b2b_done_count", done_cnt - d0, 6);

    // reset mid-conversion aborts without a done pulse
    wait_idle();
    d0 = done_cnt;
    start = 1'b1; bin_in = 14'd777;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_word", {12'b0, ssd_word}, 32'h84210);
    convert(14'd321, LZ ? 20'h80C41 : 20'h00C41, "after_abort");

    // randomized conversions against the model
    for (int i = 0; i < 40; i++) begin
      logic [13:0] v;
      if (i % 4 == 0) v = 14'($urandom_range(0, 99));
      else v = 14'($urandom_range(0, 16383));
      run_one(v, lat, bcnt);
      check("rand_latency", lat, 15);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
